// File: rtl/ats21_host_driver.sv
// Host-side initiator for the ATS21 timer/alarm device: serializes two client
// instructions onto req/ctrlA/ctrlB, retries nacked commands, and turns alarm
// data edges into sticky, clearable event flags with an interrupt.
module ats21_host_driver #(
  parameter int unsigned STAT_LAT      = 2,
  parameter int unsigned READY_TIMEOUT = 16,
  parameter int unsigned MAX_RETRY     = 3,
  parameter int unsigned NUM_ALARMS    = 24
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_a_valid,
  input  logic [31:0]           cmd_a_data,
  output logic                  cmd_a_ready,
  input  logic                  cmd_b_valid,
  input  logic [31:0]           cmd_b_data,
  output logic                  cmd_b_ready,
  output logic                  req,
  output logic [15:0]           ctrlA,
  output logic [15:0]           ctrlB,
  input  logic                  dev_ready,
  input  logic [1:0]            stat,
  input  logic [NUM_ALARMS-1:0] data,
  output logic                  rsp_valid,
  output logic [1:0]            rsp_ack,
  output logic                  rsp_timeout,
  output logic [2:0]            rsp_retries,
  output logic                  busy,
  output logic [NUM_ALARMS-1:0] evt_flags,
  input  logic [NUM_ALARMS-1:0] evt_clr,
  output logic                  evt_irq
);

  localparam int unsigned TO_W = 8;
  localparam int unsigned SL_W = 4;
  localparam int unsigned RC_W = 3;

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_WAIT_RDY, S_HI, S_LO, S_WAIT_STAT, S_RESP
  } state_t;

  state_t                state;
  logic [31:0]           inst_a, inst_b;
  logic                  pend_a, pend_b;
  logic                  acked_a, acked_b;
  logic                  timed_out;
  logic [TO_W-1:0]       tmo_cnt;
  logic [SL_W-1:0]       stat_cnt;
  logic [RC_W-1:0]       retry_cnt;
  logic [NUM_ALARMS-1:0] data_q;

  logic npend_a, npend_b, nack_a, nack_b, can_retry;

  // Client handshake is combinational so a command is taken in the cycle it is seen
  assign cmd_a_ready = !reset && (state == S_IDLE) && cmd_a_valid;
  assign cmd_b_ready = !reset && (state == S_IDLE) && cmd_b_valid;

  // Outcome of the current stat sample; non-pending clients ignore their stat bit
  always_comb begin
    npend_a   = pend_a & ~stat[0];
    npend_b   = pend_b & ~stat[1];
    nack_a    = acked_a | (pend_a & stat[0]);
    nack_b    = acked_b | (pend_b & stat[1]);
    can_retry = retry_cnt < RC_W'(MAX_RETRY);
  end

  // Command FSM; outputs are registered on the transition into the state they belong to
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      inst_a      <= '0;
      inst_b      <= '0;
      pend_a      <= 1'b0;
      pend_b      <= 1'b0;
      acked_a     <= 1'b0;
      acked_b     <= 1'b0;
      timed_out   <= 1'b0;
      tmo_cnt     <= '0;
      stat_cnt    <= '0;
      retry_cnt   <= '0;
      req         <= 1'b0;
      ctrlA       <= '0;
      ctrlB       <= '0;
      rsp_valid   <= 1'b0;
      rsp_ack     <= '0;
      rsp_timeout <= 1'b0;
      rsp_retries <= '0;
      busy        <= 1'b0;
    end else begin
      req       <= 1'b0;
      ctrlA     <= '0;
      ctrlB     <= '0;
      rsp_valid <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (cmd_a_valid || cmd_b_valid) begin
            inst_a    <= cmd_a_valid ? cmd_a_data : 32'h0000_0000;
            inst_b    <= cmd_b_valid ? cmd_b_data : 32'h0000_0000;
            pend_a    <= cmd_a_valid;
            pend_b    <= cmd_b_valid;
            acked_a   <= 1'b0;
            acked_b   <= 1'b0;
            timed_out <= 1'b0;
            retry_cnt <= '0;
            req       <= 1'b1;
            busy      <= 1'b1;
            state     <= S_REQ;
          end
        end
        S_REQ: begin
          tmo_cnt <= '0;
          state   <= S_WAIT_RDY;
        end
        S_WAIT_RDY: begin
          if (dev_ready) begin
            ctrlA <= inst_a[31:16];
            ctrlB <= inst_b[31:16];
            state <= S_HI;
          end else if (tmo_cnt == TO_W'(READY_TIMEOUT - 1)) begin
            timed_out   <= 1'b1;
            rsp_valid   <= 1'b1;
            rsp_ack     <= {acked_b, acked_a};
            rsp_timeout <= 1'b1;
            rsp_retries <= retry_cnt;
            state       <= S_RESP;
          end else begin
            tmo_cnt <= tmo_cnt + TO_W'(1);
          end
        end
        S_HI: begin
          ctrlA <= inst_a[15:0];
          ctrlB <= inst_b[15:0];
          state <= S_LO;
        end
        S_LO: begin
          stat_cnt <= SL_W'(1);
          state    <= S_WAIT_STAT;
        end
        S_WAIT_STAT: begin
          if (stat_cnt == SL_W'(STAT_LAT)) begin
            pend_a  <= npend_a;
            pend_b  <= npend_b;
            acked_a <= nack_a;
            acked_b <= nack_b;
            inst_a  <= npend_a ? inst_a : 32'h0000_0000;
            inst_b  <= npend_b ? inst_b : 32'h0000_0000;
            if (!((npend_a || npend_b) && can_retry)) begin
              rsp_valid   <= 1'b1;
              rsp_ack     <= {nack_b, nack_a};
              rsp_timeout <= 1'b0;
              rsp_retries <= retry_cnt;
            end
            state <= S_RESP;
          end else begin
            stat_cnt <= stat_cnt + SL_W'(1);
          end
        end
        S_RESP: begin
          if ((pend_a || pend_b) && !timed_out && can_retry) begin
            retry_cnt <= retry_cnt + RC_W'(1);
            req       <= 1'b1;
            state     <= S_REQ;
          end else begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Rising-edge alarm capture; a coincident new rise beats the clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q    <= '0;
      evt_flags <= '0;
      evt_irq   <= 1'b0;
    end else begin
      data_q    <= data;
      evt_flags <= (evt_flags & ~evt_clr) | (data & ~data_q);
      evt_irq   <= |evt_flags;
    end
  end

endmodule

// File: tb/tb_ats21_host_driver.sv
// Self-checking bench for ats21_host_driver: a scripted device answers each
// attempt, and a transaction-level model predicts words, acks and retries.
module tb_ats21_host_driver;

  localparam int unsigned STAT_LAT      = 2;
  localparam int unsigned READY_TIMEOUT = 16;
  localparam int unsigned MAX_RETRY     = 3;
  localparam int unsigned NUM_ALARMS    = 24;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  cmd_a_valid, cmd_b_valid;
  logic [31:0]           cmd_a_data, cmd_b_data;
  logic                  cmd_a_ready, cmd_b_ready;
  logic                  req;
  logic [15:0]           ctrlA, ctrlB;
  logic                  dev_ready;
  logic [1:0]            stat;
  logic [NUM_ALARMS-1:0] data;
  logic                  rsp_valid;
  logic [1:0]            rsp_ack;
  logic                  rsp_timeout;
  logic [2:0]            rsp_retries;
  logic                  busy;
  logic [NUM_ALARMS-1:0] evt_flags;
  logic [NUM_ALARMS-1:0] evt_clr;
  logic                  evt_irq;

  int checks = 0;
  int errors = 0;

  logic [NUM_ALARMS-1:0] ef;  // modelled event flags
  logic [NUM_ALARMS-1:0] pd;  // modelled previous data

  ats21_host_driver #(
    .STAT_LAT(STAT_LAT), .READY_TIMEOUT(READY_TIMEOUT),
    .MAX_RETRY(MAX_RETRY), .NUM_ALARMS(NUM_ALARMS)
  ) dut (
    .clk(clk), .reset(reset),
    .cmd_a_valid(cmd_a_valid), .cmd_a_data(cmd_a_data), .cmd_a_ready(cmd_a_ready),
    .cmd_b_valid(cmd_b_valid), .cmd_b_data(cmd_b_data), .cmd_b_ready(cmd_b_ready),
    .req(req), .ctrlA(ctrlA), .ctrlB(ctrlB), .dev_ready(dev_ready), .stat(stat),
    .data(data), .rsp_valid(rsp_valid), .rsp_ack(rsp_ack), .rsp_timeout(rsp_timeout),
    .rsp_retries(rsp_retries), .busy(busy), .evt_flags(evt_flags), .evt_clr(evt_clr),
    .evt_irq(evt_irq)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One client transaction; plan[2k+1:2k] is the device's stat for attempt k
  task automatic run_txn(input bit va, input logic [31:0] ia, input bit vb,
                         input logic [31:0] ib, input logic [7:0] plan,
                         input int dly, input bit tmo);
    logic [31:0] ca, cb;
    bit          pa, pb, done, ctrl_seen;
    logic [1:0]  acked, s;
    int          k, n;
    ca = va ? ia : 32'h0; cb = vb ? ib : 32'h0;
    pa = va; pb = vb; acked = 2'b00; k = 0;
    cmd_a_valid = va; cmd_a_data = ia; cmd_b_valid = vb; cmd_b_data = ib;
    #1;
    check("ready_a", cmd_a_ready, va);
    check("ready_b", cmd_b_ready, vb);
    tick;
    cmd_a_valid = 1'b0; cmd_b_valid = 1'b0;
    cmd_a_data = $urandom; cmd_b_data = $urandom;
    forever begin
      check("req", req, 1);
      check("busy", busy, 1);
      cmd_b_valid = 1'b1;
      #1 check("ready_while_busy", cmd_b_ready, 0);
      cmd_b_valid = 1'b0;
      if (tmo) begin
        n = 0; ctrl_seen = 0;
        while (!rsp_valid && n < 40) begin
          tick; n++;
          if (ctrlA != 16'h0 || ctrlB != 16'h0) ctrl_seen = 1;
        end
        check("timeout_latency", n, READY_TIMEOUT + 1);
        check("timeout_no_ctrl", ctrl_seen, 0);
        check("timeout_flag", rsp_timeout, 1);
        check("timeout_ack", rsp_ack, acked);
        check("timeout_retries", rsp_retries, k);
        break;
      end
      tick;
      check("req_one_cycle", req, 0);
      repeat (dly) tick;
      dev_ready = 1'b1;
      tick;
      dev_ready = 1'b0;
      check("ctrlA_hi", ctrlA, ca[31:16]);
      check("ctrlB_hi", ctrlB, cb[31:16]);
      tick;
      check("ctrlA_lo", ctrlA, ca[15:0]);
      check("ctrlB_lo", ctrlB, cb[15:0]);
      s = plan[2*k +: 2];
      stat = ~s;
      repeat (STAT_LAT) tick;
      stat = s;
      tick;
      stat = ~s;
      if (pa && s[0]) begin acked[0] = 1'b1; pa = 0; ca = 32'h0; end
      if (pb && s[1]) begin acked[1] = 1'b1; pb = 0; cb = 32'h0; end
      done = !(pa || pb) || (k == int'(MAX_RETRY));
      n = 0;
      while (!rsp_valid && !req && n < 8) begin tick; n++; end
      if (done) begin
        check("rsp_valid", rsp_valid, 1);
        check("rsp_ack", rsp_ack, acked);
        check("rsp_retries", rsp_retries, k);
        check("rsp_timeout", rsp_timeout, 0);
        break;
      end
      check("retry_req", req, 1);
      if (!req) break;
      k++;
    end
    tick;
    stat = 2'b00;
    check("rsp_valid_pulse", rsp_valid, 0);
    check("idle_busy", busy, 0);
    check("rsp_ack_hold", rsp_ack, acked);
  endtask

  // One cycle of alarm stimulus against the sticky-flag model
  task automatic evt_step(input logic [NUM_ALARMS-1:0] d, input logic [NUM_ALARMS-1:0] c);
    logic [NUM_ALARMS-1:0] nf;
    data = d; evt_clr = c;
    nf = (ef & ~c) | (d & ~pd);
    tick;
    check("evt_flags", evt_flags, nf);
    check("evt_irq", evt_irq, |ef);
    ef = nf; pd = d;
  endtask

  task automatic cmd_phase;
    bit va, vb;
    run_txn(1'b1, 32'h2A40_0010, 1'b0, 32'h0, 8'h01, 0, 1'b0);
    run_txn(1'b1, 32'h2200_0005, 1'b1, 32'h2400_0007, 8'h03, 0, 1'b0);
    run_txn(1'b1, 32'h1111_2222, 1'b1, 32'h3333_4444, 8'h25, 1, 1'b0);
    run_txn(1'b0, 32'h0, 1'b1, 32'h5555_6666, 8'h55, 2, 1'b0);
    run_txn(1'b1, 32'h7777_8888, 1'b0, 32'h0, 8'h00, 0, 1'b1);
    for (int i = 0; i < 40; i++) begin
      va = $urandom_range(0, 1);
      vb = va ? bit'($urandom_range(0, 1)) : 1'b1;
      run_txn(va, $urandom, vb, $urandom, 8'($urandom), $urandom_range(0, 3),
              $urandom_range(0, 9) == 0);
    end
  endtask

  task automatic evt_phase;
    evt_step(24'h000020, 24'h0);
    check("evt_bit5_set", evt_flags, 24'h000020);
    evt_step(24'h000020, 24'h0);
    check("evt_irq_next", evt_irq, 1);
    evt_step(24'h0, 24'h0);
    evt_step(24'h000020, 24'h000020);
    check("evt_set_wins", evt_flags, 24'h000020);
    evt_step(24'h0, 24'h0);
    evt_step(24'h0, 24'h000020);
    check("evt_cleared", evt_flags, 24'h0);
    evt_step(24'h0, 24'h0);
    check("evt_irq_low", evt_irq, 0);
    for (int i = 0; i < 300; i++)
      evt_step(NUM_ALARMS'($urandom & $urandom & $urandom),
               NUM_ALARMS'($urandom & $urandom));
    evt_step(24'h0, 24'hFF_FFFF);
    evt_step(24'h0, 24'h0);
  endtask

  initial begin
    bit bad;
    reset = 1'b1;
    cmd_a_valid = 1'b0; cmd_b_valid = 1'b0;
    cmd_a_data = 32'h0; cmd_b_data = 32'h0;
    dev_ready = 1'b0; stat = 2'b00;
    data = '0; evt_clr = '0;
    ef = '0; pd = '0;
    repeat (3) tick;
    check("reset_req", req, 0);
    check("reset_busy", busy, 0);
    check("reset_ctrl", {ctrlB, ctrlA}, 32'h0);
    check("reset_rsp", {rsp_valid, rsp_ack, rsp_timeout, rsp_retries}, 32'h0);
    check("reset_evt", {evt_irq, evt_flags}, 32'h0);
    check("reset_ready", {cmd_b_ready, cmd_a_ready}, 32'h0);
    reset = 1'b0;
    tick;

    fork
      cmd_phase;
      evt_phase;
    join

    // Abandon a transaction in the stat wait with an asynchronous reset
    data = 24'h000100;
    cmd_a_valid = 1'b1; cmd_a_data = 32'hABCD_1234;
    tick;
    cmd_a_valid = 1'b0;
    data = 24'h0;
    tick;
    dev_ready = 1'b1;
    tick;
    dev_ready = 1'b0;
    tick;
    tick;
    check("pre_reset_busy", busy, 1);
    check("pre_reset_evt", evt_flags, 24'h000100);
    reset = 1'b1;
    #1;
    check("midreset_busy", busy, 0);
    check("midreset_ctrl", {ctrlB, ctrlA}, 32'h0);
    check("midreset_rsp", {rsp_valid, rsp_ack, rsp_timeout, rsp_retries}, 32'h0);
    check("midreset_evt", {evt_irq, evt_flags}, 32'h0);
    tick;
    reset = 1'b0;
    stat = 2'b11;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick;
      if (rsp_valid || busy || req) bad = 1;
    end
    check("no_rsp_after_reset", bad, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
